// File: rtl/cdb_broadcaster.sv
`default_nettype none
// cdb_broadcaster: one-entry holding slot per FU, rotating-priority pick of up to CDB_WIDTH
// slots per cycle, registered CDB lanes. Optional same-cycle bypass: CDB_BYPASS_EN. Rev 1.0
module cdb_broadcaster #(
  parameter int NUM_FU    = 8,
  parameter int CDB_WIDTH = 3,
  parameter int PREG_W    = 6,
  parameter int DATA_W    = 64,
  localparam int CNT_W    = $clog2(CDB_WIDTH + 1)
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        squash_i,
  input  logic [NUM_FU-1:0]           fu_valid_i,
  input  logic [NUM_FU*PREG_W-1:0]    fu_tag_i,
  input  logic [NUM_FU*DATA_W-1:0]    fu_data_i,
  output logic [NUM_FU-1:0]           fu_ready_o,
  output logic [CDB_WIDTH-1:0]        cdb_en_o,
  output logic [CDB_WIDTH*PREG_W-1:0] cdb_tag_o,
  output logic [CDB_WIDTH*DATA_W-1:0] cdb_data_o,
  output logic [CNT_W-1:0]            cdb_cnt_o
);

  localparam int IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int LANE_W = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;

  logic [NUM_FU-1:0] slot_v_q, slot_v_d;
  logic [PREG_W-1:0] slot_tag_q  [NUM_FU];
  logic [DATA_W-1:0] slot_data_q [NUM_FU];
  logic [IDX_W-1:0]  rr_q, rr_d;

  logic [NUM_FU-1:0] cand, grant, xfer, load;
  logic [PREG_W-1:0] cand_tag  [NUM_FU];
  logic [DATA_W-1:0] cand_data [NUM_FU];

  logic [CDB_WIDTH-1:0] lane_en;
  logic [PREG_W-1:0]    lane_tag  [CDB_WIDTH];
  logic [DATA_W-1:0]    lane_data [CDB_WIDTH];
  logic [CNT_W-1:0]     lane_n;
  logic [IDX_W:0]       scan;
  logic [IDX_W-1:0]     idx;

  assign fu_ready_o = ~slot_v_q | grant;
  assign xfer       = fu_valid_i & fu_ready_o;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
`ifdef CDB_BYPASS_EN
    assign cand[i] = slot_v_q[i] | fu_valid_i[i];
    // A result granted straight from the FU is already on its way to the bus.
    assign load[i] = xfer[i] & ~(~slot_v_q[i] & grant[i]);
`else
    assign cand[i] = slot_v_q[i];
    assign load[i] = xfer[i];
`endif
    assign cand_tag[i]  = slot_v_q[i] ? slot_tag_q[i]  : fu_tag_i[i*PREG_W +: PREG_W];
    assign cand_data[i] = slot_v_q[i] ? slot_data_q[i] : fu_data_i[i*DATA_W +: DATA_W];
    assign slot_v_d[i]  = load[i] | (slot_v_q[i] & ~grant[i]);
  end

  always_comb begin
    grant   = '0;
    lane_en = '0;
    lane_n  = '0;
    rr_d    = rr_q;
    scan    = '0;
    idx     = '0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      lane_tag[k]  = '0;
      lane_data[k] = '0;
    end
    // Scan from rr_q with wraparound; grants fill lanes in scan order.
    for (int j = 0; j < NUM_FU; j++) begin
      scan = {1'b0, rr_q} + (IDX_W+1)'(j);
      if (scan >= (IDX_W+1)'(NUM_FU)) begin
        scan = scan - (IDX_W+1)'(NUM_FU);
      end
      idx = scan[IDX_W-1:0];
      if (cand[idx] && (lane_n < CNT_W'(CDB_WIDTH))) begin
        grant[idx]                    = 1'b1;
        lane_en[lane_n[LANE_W-1:0]]   = 1'b1;
        lane_tag[lane_n[LANE_W-1:0]]  = cand_tag[idx];
        lane_data[lane_n[LANE_W-1:0]] = cand_data[idx];
        rr_d   = (idx == IDX_W'(NUM_FU - 1)) ? '0 : idx + IDX_W'(1);
        lane_n = lane_n + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      slot_v_q   <= '0;
      rr_q       <= '0;
      cdb_en_o   <= '0;
      cdb_tag_o  <= '0;
      cdb_data_o <= '0;
      cdb_cnt_o  <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        slot_tag_q[i]  <= '0;
        slot_data_q[i] <= '0;
      end
    end else if (squash_i) begin
      slot_v_q   <= '0;
      rr_q       <= '0;
      cdb_en_o   <= '0;
      cdb_tag_o  <= '0;
      cdb_data_o <= '0;
      cdb_cnt_o  <= '0;
    end else begin
      slot_v_q  <= slot_v_d;
      rr_q      <= rr_d;
      cdb_en_o  <= lane_en;
      cdb_cnt_o <= lane_n;
      for (int k = 0; k < CDB_WIDTH; k++) begin
        cdb_tag_o[k*PREG_W +: PREG_W]  <= lane_tag[k];
        cdb_data_o[k*DATA_W +: DATA_W] <= lane_data[k];
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (load[i]) begin
          slot_tag_q[i]  <= fu_tag_i[i*PREG_W +: PREG_W];
          slot_data_q[i] <= fu_data_i[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_broadcaster.sv
`default_nettype none
// tb_cdb_broadcaster: directed vector table plus an asynchronous-reset sequence (default build).
module tb_cdb_broadcaster;

  logic         clock_i = 1'b0;
  logic         reset_i;
  logic         squash_i;
  logic [7:0]   fu_valid_i;
  logic [47:0]  fu_tag_i;
  logic [511:0] fu_data_i;
  logic [7:0]   fu_ready_o;
  logic [2:0]   cdb_en_o;
  logic [17:0]  cdb_tag_o;
  logic [191:0] cdb_data_o;
  logic [1:0]   cdb_cnt_o;

  int total = 0;
  int bad   = 0;

  cdb_broadcaster dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .squash_i   (squash_i),
    .fu_valid_i (fu_valid_i),
    .fu_tag_i   (fu_tag_i),
    .fu_data_i  (fu_data_i),
    .fu_ready_o (fu_ready_o),
    .cdb_en_o   (cdb_en_o),
    .cdb_tag_o  (cdb_tag_o),
    .cdb_data_o (cdb_data_o),
    .cdb_cnt_o  (cdb_cnt_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic [7:0]  valid;
    logic        squash;
    logic [47:0] tags;
    logic [7:0]  ready;   // fu_ready before the edge
    logic [2:0]  en;      // registered lanes after the edge
    logic [1:0]  cnt;
    logic [17:0] ltag;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [47:0] tseq(input int base);
    logic [47:0] t;
    for (int i = 0; i < 8; i++) t[i*6 +: 6] = 6'(base + i);
    return t;
  endfunction

  function automatic logic [47:0] tone(input int fu, input int tag);
    logic [47:0] t;
    t = '0;
    t[fu*6 +: 6] = 6'(tag);
    return t;
  endfunction

  function automatic logic [17:0] lt(input int a, input int b, input int c);
    return {6'(c), 6'(b), 6'(a)};
  endfunction

  function automatic logic [63:0] dof(input logic [5:0] t);
    return {16'hDEAD, 42'h0, t};
  endfunction

  task automatic add(input logic [7:0] v, input logic sq, input logic [47:0] t,
                     input logic [7:0] rdy, input logic [2:0] en, input logic [1:0] cnt,
                     input logic [17:0] ltg);
    vec_t x;
    x.valid = v; x.squash = sq; x.tags = t;
    x.ready = rdy; x.en = en; x.cnt = cnt; x.ltag = ltg;
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] v, input logic sq, input logic [47:0] t);
    fu_valid_i = v;
    squash_i   = sq;
    fu_tag_i   = t;
    for (int i = 0; i < 8; i++) fu_data_i[i*64 +: 64] = dof(t[i*6 +: 6]);
  endtask

  initial begin
    logic [191:0] edata;

    // Single FU2 result: 2-cycle latency
    add(8'h04, 1'b0, tone(2, 17), 8'hFF, 3'b000, 2'd0, lt(0, 0, 0));
    add(8'h00, 1'b0, '0,          8'hFF, 3'b001, 2'd1, lt(17, 0, 0));
    add(8'h00, 1'b0, '0,          8'hFF, 3'b000, 2'd0, lt(0, 0, 0));
    // Squash with nothing pending brings rr_ptr back to 0
    add(8'h00, 1'b1, '0,          8'hFF, 3'b000, 2'd0, lt(0, 0, 0));
    // All eight FUs at once
    add(8'hFF, 1'b0, tseq(20),    8'hFF, 3'b000, 2'd0, lt(0, 0, 0));
    add(8'h00, 1'b0, '0,          8'h07, 3'b111, 2'd3, lt(20, 21, 22));
    add(8'h00, 1'b0, '0,          8'h3F, 3'b111, 2'd3, lt(23, 24, 25));
    add(8'h00, 1'b0, '0,          8'hFF, 3'b011, 2'd2, lt(26, 27, 0));
    add(8'h00, 1'b0, '0,          8'hFF, 3'b000, 2'd0, lt(0, 0, 0));
    // FU0 streaming alongside FU5
    add(8'h21, 1'b0, tone(0, 1) | tone(5, 5), 8'hFF, 3'b000, 2'd0, lt(0, 0, 0));
    add(8'h01, 1'b0, tone(0, 2),  8'hFF, 3'b011, 2'd2, lt(1, 5, 0));
    add(8'h01, 1'b0, tone(0, 3),  8'hFF, 3'b001, 2'd1, lt(2, 0, 0));
    add(8'h00, 1'b0, '0,          8'hFF, 3'b001, 2'd1, lt(3, 0, 0));
    add(8'h00, 1'b0, '0,          8'hFF, 3'b000, 2'd0, lt(0, 0, 0));
    // Back-to-back on FU3: ready must stay high through grant-and-refill
    add(8'h08, 1'b0, tone(3, 9),  8'hFF, 3'b000, 2'd0, lt(0, 0, 0));
    add(8'h08, 1'b0, tone(3, 10), 8'hFF, 3'b001, 2'd1, lt(9, 0, 0));
    add(8'h00, 1'b0, '0,          8'hFF, 3'b001, 2'd1, lt(10, 0, 0));
    add(8'h00, 1'b0, '0,          8'hFF, 3'b000, 2'd0, lt(0, 0, 0));
    // Fill, drain three (rr_ptr=4), squash with 5 occupied and FU1 valid
    add(8'hFF, 1'b0, tseq(30),    8'hFF, 3'b000, 2'd0, lt(0, 0, 0));
    add(8'h00, 1'b0, '0,          8'h70, 3'b111, 2'd3, lt(34, 35, 36));
    add(8'h02, 1'b1, tone(1, 45), 8'hF3, 3'b000, 2'd0, lt(0, 0, 0));
    add(8'h00, 1'b0, '0,          8'hFF, 3'b000, 2'd0, lt(0, 0, 0));
    add(8'hFF, 1'b0, tseq(50),    8'hFF, 3'b000, 2'd0, lt(0, 0, 0));
    add(8'h00, 1'b0, '0,          8'h07, 3'b111, 2'd3, lt(50, 51, 52));

    reset_i = 1'b1;
    drive(8'h00, 1'b0, '0);
    repeat (2) @(posedge clock_i);
    #3 reset_i = 1'b0;
    #1;
    chk("reset en",    192'(cdb_en_o),   192'(3'b000));
    chk("reset cnt",   192'(cdb_cnt_o),  192'(2'd0));
    chk("reset tag",   192'(cdb_tag_o),  192'(18'd0));
    chk("reset data",  cdb_data_o,       192'd0);
    chk("reset ready", 192'(fu_ready_o), 192'(8'hFF));

    @(posedge clock_i); #1;
    foreach (vecs[r]) begin
      drive(vecs[r].valid, vecs[r].squash, vecs[r].tags);
      #1;
      chk($sformatf("row%0d ready", r), 192'(fu_ready_o), 192'(vecs[r].ready));
      @(posedge clock_i); #1;
      for (int k = 0; k < 3; k++)
        edata[k*64 +: 64] = vecs[r].en[k] ? dof(vecs[r].ltag[k*6 +: 6]) : 64'd0;
      chk($sformatf("row%0d en", r),   192'(cdb_en_o),  192'(vecs[r].en));
      chk($sformatf("row%0d cnt", r),  192'(cdb_cnt_o), 192'(vecs[r].cnt));
      chk($sformatf("row%0d tag", r),  192'(cdb_tag_o), 192'(vecs[r].ltag));
      chk($sformatf("row%0d data", r), cdb_data_o,      edata);
    end

    // Mid-cycle asynchronous reset while slots 3..7 are still pending
    drive(8'h00, 1'b0, '0);
    #2 reset_i = 1'b1;
    #1;
    chk("async en",    192'(cdb_en_o),   192'(3'b000));
    chk("async cnt",   192'(cdb_cnt_o),  192'(2'd0));
    chk("async ready", 192'(fu_ready_o), 192'(8'hFF));
    #1 reset_i = 1'b0;
    @(posedge clock_i); #1;
    chk("post-reset en",    192'(cdb_en_o),   192'(3'b000));
    chk("post-reset ready", 192'(fu_ready_o), 192'(8'hFF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
